// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the seven-segment scan block.
//   NUM_DIGITS     : number of multiplexed digits
//   SEG_BLANK      : active-low segment pattern with every segment off
//   AN_OFF         : active-low anode pattern with every digit off
//   HEX_SEG_TABLE  : hex code -> active-low {g,f,e,d,c,b,a}, indexed by code
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Concatenation lists the highest index first, so code F leads.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_segments(input digit_t code);
        return HEX_SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational hex digit decoder for a common-anode display.
//   i_code : 4-bit hex digit code
//   o_seg  : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = hex_segments(digit_t'(i_code));

endmodule

// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
// Double-buffered, time-multiplexed driver for four common-anode
// seven-segment digits with optional whole-display blink.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   disp_word  : four digit codes, [3:0] rightmost, [15:12] leftmost
//   digit_en   : per-digit enable, 0 blanks that digit
//   load       : one-cycle strobe, captures disp_word/digit_en into shadow
//   blink_en   : level, blanks the display during the odd blink phase
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         : decimal point, active-low, always off
//   an         : anodes, active-low, an[0] = rightmost digit, registered
//   frame_done : one-cycle pulse on the cycle that ends a 4-digit frame
//   pending    : shadow holds a word not yet committed to the display
// Newly loaded words only reach the display on a frame boundary, so a
// frame is never drawn from two different words.
// ---------------------------------------------------------------------------
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] disp_word,
    input  logic [3:0]  digit_en,
    input  logic        load,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE   = TW'(REFRESH_DIV - 2);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

    logic [TW-1:0] r_tick;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [15:0]   r_shadow_word;
    logic [3:0]    r_shadow_mask;
    logic [15:0]   r_active_word;
    logic [3:0]    r_active_mask;
    logic          r_pending;
    logic          r_frame_done;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_tick_last;
    logic          w_blink_last;
    logic          w_frame_edge;
    logic          w_lit;
    digit_t        w_digit_codes [NUM_DIGITS];
    logic [3:0]    w_anode_sel;
    digit_t        w_digit_code;
    logic [6:0]    w_seg_decoded;

    assign w_tick_last  = (r_tick == TICK_LAST);
    assign w_blink_last = (r_blink_cnt == BLINK_LAST);
    assign w_frame_edge = w_tick_last && (r_idx == IDX_LAST);

    // Split the active word into per-digit codes and build the one-hot
    // select for the digit currently being scanned.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digit_codes[gi] = r_active_word[gi*4 +: 4];
            assign w_anode_sel[gi]   = (r_idx == 2'(gi));
        end
    endgenerate

    assign w_digit_code = w_digit_codes[r_idx];
    assign w_lit        = r_active_mask[r_idx] && !(blink_en && r_blink_phase);

    hex_to_seg u_hex_to_seg (
        .i_code (w_digit_code),
        .o_seg  (w_seg_decoded)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick        <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_shadow_word <= '0;
            r_shadow_mask <= '0;
            r_active_word <= '0;
            r_active_mask <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_seg         <= SEG_BLANK;
            r_an          <= AN_OFF;
        end else begin
            r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
            if (w_tick_last) begin
                r_idx <= r_idx + 1'b1;
            end

            r_blink_cnt <= w_blink_last ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_last) begin
                r_blink_phase <= ~r_blink_phase;
            end

            // Registered one cycle early so the pulse coincides with the
            // terminal-count cycle of the last digit.
            r_frame_done <= (r_tick == TICK_PRE) && (r_idx == IDX_LAST);

            if (load) begin
                r_shadow_word <= disp_word;
                r_shadow_mask <= digit_en;
            end

            // A load on the boundary cycle bypasses the shadow so the
            // newest word wins and nothing is left pending.
            if (w_frame_edge) begin
                if (load) begin
                    r_active_word <= disp_word;
                    r_active_mask <= digit_en;
                end else if (r_pending) begin
                    r_active_word <= r_shadow_word;
                    r_active_mask <= r_shadow_mask;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            // Anode and segments are both derived from the same index in
            // the same register stage, so digits never overlap.
            r_an  <= w_lit ? ~w_anode_sel : AN_OFF;
            r_seg <= w_lit ? w_seg_decoded : SEG_BLANK;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign dp         = 1'b1;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
